// File: rtl/adc_scan_sequencer.sv
// Scan controller for the LTC2308 driver: converts each enabled channel once per sample period,
// forwards tagged results and flags overruns and stuck conversions.
module adc_scan_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned START_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  channel_mask,
  input  logic [15:0] period_cycles,
  output logic        measure_start,
  output logic [2:0]  measure_ch,
  input  logic        measure_done,
  input  logic [11:0] measure_dataread,
  output logic [11:0] data_out,
  output logic [2:0]  data_ch,
  output logic        data_valid,
  output logic        scan_done,
  output logic        busy,
  output logic        overrun_err,
  output logic        timeout_err
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned StW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StSetup,
    StStart,
    StWaitDone,
    StCapture
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   period_cnt_q, period_cnt_d;
  logic [7:0]    scan_mask_q, scan_mask_d;
  logic [StW-1:0] start_cnt_q, start_cnt_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic          measure_start_q, measure_start_d;
  logic [2:0]    measure_ch_q, measure_ch_d;
  logic [11:0]   data_out_q, data_out_d;
  logic [2:0]    data_ch_q, data_ch_d;
  logic          data_valid_q, data_valid_d;
  logic          scan_done_q, scan_done_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          tick;
  logic [2:0]    low_idx;

  assign tick = enable && (period_cnt_q == 16'd0);

  // Period 0 and 1 both reload 0, giving a tick on every enabled cycle.
  always_comb begin
    if (!enable) begin
      period_cnt_d = 16'd0;
    end else if (tick) begin
      period_cnt_d = (period_cycles == 16'd0) ? 16'd0 : period_cycles - 16'd1;
    end else begin
      period_cnt_d = period_cnt_q - 16'd1;
    end
  end

  // Descending scan so the lowest set bit wins.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (scan_mask_q[i]) begin
        low_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    scan_mask_d  = scan_mask_q;
    start_cnt_d  = start_cnt_q;
    to_cnt_d     = '0;
    measure_ch_d = measure_ch_q;
    data_out_d   = data_out_q;
    data_ch_d    = data_ch_q;
    data_valid_d = 1'b0;
    scan_done_d  = 1'b0;
    // Ticks outside IDLE are dropped, including the cycle the scan wraps up.
    overrun_d    = overrun_q | (tick && (state_q != StIdle));
    timeout_d    = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (tick && (channel_mask != 8'd0)) begin
          scan_mask_d = channel_mask;
          state_d     = StSelect;
        end
      end
      StSelect: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (scan_mask_q == 8'd0) begin
          scan_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          measure_ch_d         = low_idx;
          scan_mask_d[low_idx] = 1'b0;
          state_d              = StSetup;
        end
      end
      StSetup: begin
        start_cnt_d = '0;
        state_d     = StStart;
      end
      StStart: begin
        if (start_cnt_q == StW'(START_CYCLES - 1)) begin
          state_d = StWaitDone;
        end else begin
          start_cnt_d = start_cnt_q + StW'(1);
        end
      end
      StWaitDone: begin
        if (measure_done) begin
          state_d = StCapture;
        end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = StSelect;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StCapture: begin
        data_out_d   = measure_dataread;
        data_ch_d    = measure_ch_q;
        data_valid_d = 1'b1;
        state_d      = StSelect;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    measure_start_d = (state_d == StStart);
    busy_d          = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      period_cnt_q    <= 16'd0;
      scan_mask_q     <= 8'd0;
      start_cnt_q     <= '0;
      to_cnt_q        <= '0;
      measure_start_q <= 1'b0;
      measure_ch_q    <= 3'd0;
      data_out_q      <= 12'd0;
      data_ch_q       <= 3'd0;
      data_valid_q    <= 1'b0;
      scan_done_q     <= 1'b0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      period_cnt_q    <= period_cnt_d;
      scan_mask_q     <= scan_mask_d;
      start_cnt_q     <= start_cnt_d;
      to_cnt_q        <= to_cnt_d;
      measure_start_q <= measure_start_d;
      measure_ch_q    <= measure_ch_d;
      data_out_q      <= data_out_d;
      data_ch_q       <= data_ch_d;
      data_valid_q    <= data_valid_d;
      scan_done_q     <= scan_done_d;
      busy_q          <= busy_d;
      overrun_q       <= overrun_d;
      timeout_q       <= timeout_d;
    end
  end

  assign measure_start = measure_start_q;
  assign measure_ch    = measure_ch_q;
  assign data_out      = data_out_q;
  assign data_ch       = data_ch_q;
  assign data_valid    = data_valid_q;
  assign scan_done     = scan_done_q;
  assign busy          = busy_q;
  assign overrun_err   = overrun_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: driver model, scoreboard of expected results and a
// negedge monitor that checks each data_valid and records handshake timing.
module tb_adc_scan_sequencer;

  localparam int Lat = 78;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  channel_mask;
  logic [15:0] period_cycles;
  logic        measure_start;
  logic [2:0]  measure_ch;
  logic        measure_done;
  logic [11:0] measure_dataread;
  logic [11:0] data_out;
  logic [2:0]  data_ch;
  logic        data_valid;
  logic        scan_done;
  logic        busy;
  logic        overrun_err;
  logic        timeout_err;
  logic [7:0]  stuck_mask;

  adc_scan_sequencer #(
    .TIMEOUT_CYCLES(255),
    .START_CYCLES  (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .channel_mask    (channel_mask),
    .period_cycles   (period_cycles),
    .measure_start   (measure_start),
    .measure_ch      (measure_ch),
    .measure_done    (measure_done),
    .measure_dataread(measure_dataread),
    .data_out        (data_out),
    .data_ch         (data_ch),
    .data_valid      (data_valid),
    .scan_done       (scan_done),
    .busy            (busy),
    .overrun_err     (overrun_err),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
  } exp_t;
  exp_t exp_q[$];

  int         sd_cnt;
  int         start_cnt;
  logic       busy_seen;
  int         busy_rise[$];
  logic [2:0] start_chs[$];
  int         ms_fall_cyc;
  int         to_rise_cyc;
  int         ov_rise_cyc;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] ch);
    exp_t e;
    e.ch   = ch;
    e.data = 12'h100 + 12'(ch);
    exp_q.push_back(e);
  endtask

  task automatic clear_stats();
    sd_cnt      = 0;
    start_cnt   = 0;
    busy_seen   = 1'b0;
    ms_fall_cyc = 0;
    to_rise_cyc = 0;
    ov_rise_cyc = 0;
    busy_rise.delete();
    start_chs.delete();
    exp_q.delete();
  endtask

  task automatic reset_run(input logic [7:0] mask, input logic [15:0] per, input logic [7:0] stk);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    channel_mask  = mask;
    period_cycles = per;
    stuck_mask    = stk;
    clear_stats();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic wait_sd(input int n, input int budget, input string nm);
    int k = 0;
    while (sd_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, sd_cnt, n);
  endtask

  task automatic wait_starts(input int n, input int budget, input string nm);
    int k = 0;
    while (start_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, start_cnt, n);
  endtask

  // Driver model: done rises Lat cycles after the start edge, except on stuck channels.
  initial begin : drv
    int         cnt;
    logic       armed;
    logic       prev;
    logic [2:0] ch;
    measure_done     = 1'b0;
    measure_dataread = 12'd0;
    cnt = 0; armed = 1'b0; prev = 1'b0; ch = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        measure_done = 1'b0;
        armed        = 1'b0;
        prev         = 1'b0;
      end else if (measure_start && !prev) begin
        measure_done = 1'b0;
        ch           = measure_ch;
        armed        = !stuck_mask[ch];
        cnt          = Lat;
        prev         = 1'b1;
      end else begin
        prev = measure_start;
        if (armed) begin
          cnt--;
          if (cnt == 0) begin
            measure_done     = 1'b1;
            measure_dataread = 12'h100 + 12'(ch);
            armed            = 1'b0;
          end
        end
      end
    end
  end

  initial begin : mon
    logic ms_p, busy_p, to_p, ov_p;
    exp_t e;
    ms_p = 1'b0; busy_p = 1'b0; to_p = 1'b0; ov_p = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got ch=%0d data=0x%0h, expected no data_valid",
                   data_ch, data_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ch", int'(data_ch), int'(e.ch));
          chk("sb_data", int'(data_out), int'(e.data));
        end
      end
      if (data_valid && scan_done) begin
        n_checks++;
        n_fail++;
        $display("FAIL valid_with_scan_done: got both high at cycle %0d, expected apart", cyc);
      end
      if (scan_done) sd_cnt++;
      if (measure_start && !ms_p) begin
        start_cnt++;
        start_chs.push_back(measure_ch);
      end
      if (!measure_start && ms_p) ms_fall_cyc = cyc;
      if (busy) busy_seen = 1'b1;
      if (busy && !busy_p) busy_rise.push_back(cyc);
      if (timeout_err && !to_p) to_rise_cyc = cyc;
      if (overrun_err && !ov_p) ov_rise_cyc = cyc;
      ms_p   = measure_start;
      busy_p = busy;
      to_p   = timeout_err;
      ov_p   = overrun_err;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r;
    reset         = 1'b1;
    enable        = 1'b0;
    channel_mask  = 8'd0;
    period_cycles = 16'd0;
    stuck_mask    = 8'd0;
    clear_stats();
    repeat (3) @(negedge clk);
    chk("rst_measure_start", measure_start, 0);
    chk("rst_measure_ch", measure_ch, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun_err, 0);
    chk("rst_timeout", timeout_err, 0);

    // Two channels, long period: scans 1000 cycles apart, no flags.
    reset_run(8'h05, 16'd1000, 8'h00);
    for (int i = 0; i < 2; i++) begin
      push_exp(3'd0);
      push_exp(3'd2);
    end
    wait_sd(2, 2600, "s1_scan_done_count");
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("s1_queue_left", exp_q.size(), 0);
    chk("s1_overrun", overrun_err, 0);
    chk("s1_timeout", timeout_err, 0);
    chk("s1_start_count", start_cnt, 4);
    for (int i = 0; i < start_chs.size() && i < 4; i++) chk("s1_order", start_chs[i], (i % 2) * 2);
    chk("s1_scan_starts", busy_rise.size(), 2);
    if (busy_rise.size() >= 2) chk("s1_period", busy_rise[1] - busy_rise[0], 1000);

    // All channels, period shorter than the scan: overrun, scans restart on the 700 tick.
    reset_run(8'hFF, 16'd100, 8'h00);
    for (int i = 0; i < 16; i++) push_exp(3'(i % 8));
    wait_sd(2, 2000, "s2_scan_done_count");
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("s2_queue_left", exp_q.size(), 0);
    chk("s2_overrun", overrun_err, 1);
    chk("s2_timeout", timeout_err, 0);
    chk("s2_start_count", start_cnt, 16);
    chk("s2_busy_after", busy, 0);
    chk("s2_scan_starts", busy_rise.size(), 2);
    if (busy_rise.size() >= 2) begin
      chk("s2_overrun_time", ov_rise_cyc - busy_rise[0], 100);
      chk("s2_rescan_gap", busy_rise[1] - busy_rise[0], 700);
    end

    // Channel 3 never completes: timeout 255 cycles after its start falls.
    reset_run(8'h0C, 16'd2000, 8'h08);
    push_exp(3'd2);
    wait_sd(1, 800, "s3_scan_done_count");
    repeat (3) @(negedge clk);
    chk("s3_timeout", timeout_err, 1);
    chk("s3_timeout_time", to_rise_cyc - ms_fall_cyc, 255);
    chk("s3_start_count", start_cnt, 2);
    if (start_chs.size() >= 2) begin
      chk("s3_first_ch", start_chs[0], 2);
      chk("s3_second_ch", start_chs[1], 3);
    end
    chk("s3_queue_left", exp_q.size(), 0);
    chk("s3_overrun", overrun_err, 0);
    stuck_mask = 8'h00;

    // Empty mask with ticks every cycle: nothing happens.
    reset_run(8'h00, 16'd0, 8'h00);
    repeat (300) @(negedge clk);
    chk("s4_start_count", start_cnt, 0);
    chk("s4_busy_seen", busy_seen, 0);
    chk("s4_scan_done", sd_cnt, 0);
    chk("s4_overrun", overrun_err, 0);

    // Enable dropped during ch1: ch1 result still delivered, ch2 never started.
    reset_run(8'h07, 16'd1000, 8'h00);
    push_exp(3'd0);
    push_exp(3'd1);
    wait_starts(2, 400, "s5_reach_ch1");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("s5_busy", busy, 0);
    chk("s5_start_count", start_cnt, 2);
    if (start_chs.size() >= 2) chk("s5_second_ch", start_chs[1], 1);
    chk("s5_scan_done", sd_cnt, 0);
    chk("s5_queue_left", exp_q.size(), 0);

    // Reset in the middle of START: outputs clear at once, restart from ch0.
    reset_run(8'h03, 16'd1000, 8'h00);
    push_exp(3'd0);
    wait_starts(2, 400, "s6_reach_ch1");
    #1;
    reset = 1'b1;
    #1;
    chk("s6_measure_start", measure_start, 0);
    chk("s6_busy", busy, 0);
    chk("s6_measure_ch", measure_ch, 0);
    chk("s6_data_out", data_out, 0);
    chk("s6_data_valid", data_valid, 0);
    chk("s6_queue_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    clear_stats();
    push_exp(3'd0);
    push_exp(3'd1);
    r     = cyc;
    reset = 1'b0;
    wait_sd(1, 400, "s6_scan_done_count");
    repeat (3) @(negedge clk);
    chk("s6_restart_scans", busy_rise.size(), 1);
    if (busy_rise.size() >= 1) chk("s6_restart_time", busy_rise[0] - r, 1);
    if (start_chs.size() >= 1) chk("s6_restart_ch", start_chs[0], 0);
    chk("s6_restart_queue", exp_q.size(), 0);

    enable = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
